pipe_adder: RTL and testbench

Parametrised, pipelined unsigned adder with carry-in and a valid/ready handshake on both sides. The WIDTH-bit carry chain is split into STAGES equal chunks, and one chunk is resolved per clock, so wide adds close timing at high clock rates. It is the sequential successor to the fixed 4-bit combinational adder. Arithmetic datapaths use it where a one-cycle-per-operand stream at high frequency is needed.

---
 rtl/pipe_adder.sv | 106 ++++++++++
 tb/tb_pipe_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined unsigned adder: WIDTH-bit carry chain split into STAGES chunks, one chunk per clock.
// Optional macro PIPE_ADDER_SAT_EN: the final stage saturates to all ones on carry-out.
module pipe_adder #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
);

   localparam int unsigned CHUNK = WIDTH / STAGES;
   localparam int unsigned LAST  = STAGES - 1;

   logic en_c;

   if (WIDTH < 2 || STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be >= 2 and an exact multiple of STAGES");
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned LO  = k * CHUNK;
      localparam int unsigned REM = WIDTH - LO - CHUNK;

      logic                  v_src;
      logic                  cy_src;
      logic [WIDTH-LO-1:0]   a_src;
      logic [WIDTH-LO-1:0]   b_src;
      logic [LO+CHUNK-1:0]   res_raw;
      logic [LO+CHUNK-1:0]   res_nxt;
      logic [CHUNK:0]        add_c;
      logic                  v_q;
      logic                  cy_q;
      logic [LO+CHUNK-1:0]   res_q;

      // Stage inputs: ports for stage 0, previous stage registers otherwise
      if (k == 0) begin : g_src
         assign v_src   = in_valid;
         assign cy_src  = cin;
         assign a_src   = a;
         assign b_src   = b;
         assign res_raw = add_c[CHUNK-1:0];
      end else begin : g_src
         assign v_src   = g_stage[k-1].v_q;
         assign cy_src  = g_stage[k-1].cy_q;
         assign a_src   = g_stage[k-1].g_ops.a_q;
         assign b_src   = g_stage[k-1].g_ops.b_q;
         assign res_raw = {add_c[CHUNK-1:0], g_stage[k-1].res_q};
      end

      assign add_c = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                   + (CHUNK+1)'(cy_src);

`ifdef PIPE_ADDER_SAT_EN
      if (k == LAST) begin : g_res
         assign res_nxt = add_c[CHUNK] ? {(LO+CHUNK){1'b1}} : res_raw;
      end else begin : g_res
         assign res_nxt = res_raw;
      end
`else
      assign res_nxt = res_raw;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            cy_q  <= 1'b0;
            res_q <= '0;
         end else if (en_c) begin
            v_q   <= v_src;
            cy_q  <= add_c[CHUNK];
            res_q <= res_nxt;
         end
      end

      // Upper operand chunks still waiting for their stage
      if (REM > 0) begin : g_ops
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en_c) begin
               a_q <= a_src[WIDTH-LO-1:CHUNK];
               b_q <= b_src[WIDTH-LO-1:CHUNK];
            end
         end
      end
   end

   // Whole pipe advances in lockstep; only a full, unconsumed last stage stalls it
   assign en_c      = !g_stage[LAST].v_q || out_ready;
   assign in_ready  = en_c;
   assign out_valid = g_stage[LAST].v_q;
   assign sum       = {g_stage[LAST].cy_q, g_stage[LAST].res_q};

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: queue-based reference model plus directed vectors and a WIDTH=32 stage sweep.
module tb_pipe_adder;

   localparam int unsigned NVEC = 20;
   localparam int unsigned NSW  = 3;

`ifdef PIPE_ADDER_SAT_EN
   localparam logic [8:0] EXP_CARRY = 9'h1FF;
   localparam logic [8:0] EXP_8080  = 9'h1FF;
`else
   localparam logic [8:0] EXP_CARRY = 9'h101;
   localparam logic [8:0] EXP_8080  = 9'h100;
`endif

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] sum;

   logic            in_valid32;
   logic [31:0]     a32;
   logic [31:0]     b32;
   logic            cin32;
   logic [NSW-1:0]  ir32;
   logic [NSW-1:0]  ov32;
   logic [32:0]     sum32 [NSW];

   logic [31:0] sa [NVEC];
   logic [31:0] sb [NVEC];
   logic        sc [NVEC];
   int          scyc [NVEC];

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [8:0]  q [$];
   logic [32:0] m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: exact w-bit add with carry-out, optionally saturated
   function automatic logic [32:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic c);
      logic [32:0] msk;
      logic [32:0] s;
      msk = (33'd1 << w) - 33'd1;
      s = ({1'b0, x} & msk) + ({1'b0, y} & msk) + 33'(c);
`ifdef PIPE_ADDER_SAT_EN
      if (s[w]) s = (msk << 1) | 33'd1;
`endif
      return s;
   endfunction

   pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
   );

   // Scoreboard: push on accept, pop on deliver, flush on reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) void'(q.pop_front());
         if (in_valid && in_ready) begin
            m = model(8, 32'(a), 32'(b), cin);
            q.push_back(m[8:0]);
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
         if (out_valid) begin
            check("out_valid_expected", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) check("stream_sum", 64'(sum), 64'(q[0]));
         end
      end
   end

   for (genvar k = 0; k < NSW; k++) begin : g_sw
      localparam int unsigned S = (k == 0) ? 1 : (k == 1) ? 4 : 8;
      int rx = 0;

      pipe_adder #(.WIDTH(32), .STAGES(S)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid32),
         .in_ready  (ir32[k]),
         .a         (a32),
         .b         (b32),
         .cin       (cin32),
         .out_valid (ov32[k]),
         .out_ready (1'b1),
         .sum       (sum32[k])
      );

      always @(negedge clk) begin
         #1;
         if (rst_n && ov32[k]) begin
            if (rx < int'(NVEC)) begin
               check("sweep_sum", 64'(sum32[k]), 64'(model(32, sa[rx], sb[rx], sc[rx])));
               check("sweep_latency", 64'(cyc - scyc[rx]), 64'(S));
            end else begin
               check("sweep_extra_out", 64'(ov32[k]), 64'(0));
            end
            rx++;
         end
      end
   end

   task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
      int   tries;
      logic acc;
      tries = 0;
      acc = 1'b0;
      a = xa; b = xb; cin = xc; in_valid = 1'b1;
      while (!acc && tries < 20) begin
         #1 acc = in_ready;
         @(negedge clk);
         tries++;
      end
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 64'(acc), 64'(1));
   endtask

   task automatic single(input string nm, input logic [7:0] xa, input logic [7:0] xb,
                         input logic xc, input logic [8:0] exp);
      a = xa; b = xb; cin = xc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check({nm, "_early"}, 64'(out_valid), 64'(0));
      @(negedge clk);
      check({nm, "_valid"}, 64'(out_valid), 64'(1));
      check({nm, "_sum"}, 64'(sum), 64'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int         cnt;
      int         first;
      int         last;
      logic [8:0] last_sum;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;

      check("model_pin_basic", 64'(model(8, 32'h0F, 32'h01, 1'b0)), 64'h010);
      check("model_pin_carry", 64'(model(8, 32'hFF, 32'h01, 1'b1)), 64'(EXP_CARRY));
      check("model_pin_w32", 64'(model(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1)), 64'h1_FFFF_FFFF);

      repeat (2) @(negedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_sum", 64'(sum), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      single("basic", 8'h0F, 8'h01, 1'b0, 9'h010);
      single("carry", 8'hFF, 8'h01, 1'b1, EXP_CARRY);

      // 16 back-to-back operands with a free-running consumer
      cnt = 0; first = -1; last = -1; last_sum = '0;
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            a = 8'(i); b = 8'(2 * i); cin = i[0]; in_valid = 1'b1;
            #1 check("stream_in_ready", 64'(in_ready), 64'(1));
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         #1;
         if (out_valid) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
            last_sum = sum;
         end
      end
      check("stream_count", 64'(cnt), 64'(16));
      check("stream_contiguous", 64'(last - first + 1), 64'(16));
      check("stream_last_sum", 64'(last_sum), 64'h02E);

      // Fill the pipe with the consumer stalled, then hold three cycles
      out_ready = 1'b0;
      send(8'h10, 8'h20, 1'b0);
      send(8'h11, 8'h20, 1'b0);
      a = 8'h12; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_out_valid", 64'(out_valid), 64'(1));
         check("bp_sum_held", 64'(sum), 64'h030);
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(8'h12, 8'h20, 1'b0);
      repeat (5) @(negedge clk);
      check("bp_drain_empty", 64'(q.size()), 64'(0));

      // Asynchronous reset with two operations in flight
      out_ready = 1'b0;
      send(8'h05, 8'h06, 1'b0);
      send(8'h07, 8'h08, 1'b1);
      check("pre_reset_valid", 64'(out_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check("midreset_out_valid", 64'(out_valid), 64'(0));
      check("midreset_sum", 64'(sum), 64'(0));
      check("midreset_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      single("post_reset", 8'h80, 8'h80, 1'b0, EXP_8080);
      repeat (3) @(negedge clk);

      // WIDTH=32 sweep over STAGES 1, 4, 8
      for (int i = 0; i < int'(NVEC); i++) begin
         if (i == 0) begin
            a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1;
         end else if (i == 1) begin
            a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; cin32 = 1'b1;
         end else begin
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
         end
         sa[i] = a32; sb[i] = b32; sc[i] = cin32; scyc[i] = cyc;
         in_valid32 = 1'b1;
         #1 check("sweep_in_ready", 64'(ir32), 64'(3'b111));
         @(negedge clk);
      end
      in_valid32 = 1'b0;
      repeat (12) @(negedge clk);
      check("sweep_count_s1", 64'(g_sw[0].rx), 64'(NVEC));
      check("sweep_count_s4", 64'(g_sw[1].rx), 64'(NVEC));
      check("sweep_count_s8", 64'(g_sw[2].rx), 64'(NVEC));
      check("final_queue_empty", 64'(q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
